// File: rtl/traffic_gen.sv
// traffic_gen: scrolling 16x16 obstacle grid for the road game.
// Each enabled row is a lane of 2-pixel cars fed from a Galois LFSR.
// Even lanes scroll +x and odd lanes scroll -x. Lanes with y[1]=1 move
// at half speed. freeze stalls everything; clear blanks the road but
// keeps the LFSR running sequence.
// Optional feature macro TRAFFIC_SPEEDUP_EN: adds a 2-bit `level` input
// that divides the scroll period by 2^level (minimum period 2 cycles).
module traffic_gen #(
    parameter logic [24:0] TICK_DIV  = 25'd12500000,
    parameter logic [15:0] LANE_MASK = 16'h7E7E,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              clear,
`ifdef TRAFFIC_SPEEDUP_EN
    input  logic [1:0]        level,
`endif
    output logic [15:0][15:0] RedPixels,
    output logic              step
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [24:0] TC_FULL  = TICK_DIV - 25'd1;

    logic [24:0] tick_cnt;
    logic [24:0] tick_tc;
    logic        tick_now;
    logic        parity;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

`ifdef TRAFFIC_SPEEDUP_EN
    logic [24:0] div_shift;
    logic [24:0] level_tc;

    // Terminal count for the requested speed level, floored at 1.
    always_comb begin
        div_shift = TICK_DIV >> level;
        level_tc  = (div_shift < 25'd3) ? 25'd1 : (div_shift - 25'd1);
    end

    // Period is latched at each wrap so a level change never cuts a period short.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_tc <= TC_FULL;
        end else if (clear || tick_now) begin
            tick_tc <= level_tc;
        end
    end
`else
    assign tick_tc = TC_FULL;
`endif

    assign tick_now = !freeze && (tick_cnt == tick_tc);
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Tick counter, half-speed parity, LFSR and step pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            parity   <= 1'b0;
            lfsr     <= SEED_EFF;
            step     <= 1'b0;
        end else if (clear) begin
            tick_cnt <= '0;
            parity   <= 1'b0;
            step     <= 1'b0;
        end else begin
            step <= tick_now;
            if (tick_now) begin
                tick_cnt <= '0;
                parity   <= ~parity;
                lfsr     <= lfsr_nxt;
            end else if (!freeze) begin
                tick_cnt <= tick_cnt + 25'd1;
            end
        end
    end

    for (genvar gy = 0; gy < 16; gy++) begin : g_lane
        logic [15:0] row_q;

        if (LANE_MASK[gy]) begin : g_on
            localparam bit SLOW    = ((gy / 2) % 2) == 1;
            localparam bit DIR_NEG = (gy % 2) == 1;

            logic [1:0] cnt_q;
            logic [1:0] cnt_n;
            logic       entry;
            logic       shift_en;

            // Slow lanes move on the tick where parity is 1 before it toggles.
            assign shift_en = tick_now && (!SLOW || parity);

            // Car shaper: a fresh LFSR hit emits head, tail, then two forced gap pixels.
            always_comb begin
                entry = 1'b0;
                cnt_n = cnt_q;
                case (cnt_q)
                    2'd0: begin
                        entry = lfsr[gy];
                        cnt_n = lfsr[gy] ? 2'd3 : 2'd0;
                    end
                    2'd3: begin
                        entry = 1'b1;
                        cnt_n = 2'd2;
                    end
                    2'd2: cnt_n = 2'd1;
                    default: cnt_n = 2'd0;
                endcase
            end

            // Lane pixels scroll toward the lane's exit edge on each shift.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    row_q <= '0;
                    cnt_q <= 2'd0;
                end else if (clear) begin
                    row_q <= '0;
                    cnt_q <= 2'd0;
                end else if (shift_en) begin
                    cnt_q <= cnt_n;
                    if (DIR_NEG) begin
                        row_q <= {entry, row_q[15:1]};
                    end else begin
                        row_q <= {row_q[14:0], entry};
                    end
                end
            end
        end else begin : g_off
            assign row_q = '0;
        end

        for (genvar gx = 0; gx < 16; gx++) begin : g_px
            assign RedPixels[gx][gy] = row_q[gx];
        end
    end

endmodule

// File: tb/tb_traffic_gen.sv
// Bench for traffic_gen: directed reset/freeze/clear steps, then a long
// randomized run compared cycle by cycle against a lane-level model.
module tb_traffic_gen;

    localparam int          TDIV = 4;
    localparam logic [15:0] MASK = 16'h7E7E;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic              freeze = 1'b0;
    logic              clear  = 1'b0;
    logic [1:0]        level  = 2'd0;
    logic [15:0][15:0] RedPixels;
    logic              step;

    always #5 clk = ~clk;

    traffic_gen #(.TICK_DIV(25'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .freeze    (freeze),
        .clear     (clear),
`ifdef TRAFFIC_SPEEDUP_EN
        .level     (level),
`endif
        .RedPixels (RedPixels),
        .step      (step)
    );

    int n_checks;
    int n_pass;

    // Reference model: road as [lane][x], each lane with a queue of pending pixels.
    bit          m_grid [16][16];
    logic [2:0]  pend   [16];
    int          pend_n [16];
    bit          m_shift[16];
    int          m_cnt;
    int          m_tc;
    bit          m_par;
    bit          m_step;
    logic [15:0] m_lfsr;

    bit track;
    int n_steps;
    int sh_cnt  [16];
    int run_len [16];
    bit run_val [16];
    bit seen_one[16];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int calc_tc(input int lv);
        int p;
        p = TDIV >> lv;
        if (p - 1 < 1) return 1;
        return p - 1;
    endfunction

    function automatic logic [255:0] exp_grid();
        logic [255:0] v;
        v = '0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                v[x*16 + y] = m_grid[y][x];
        return v;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_tc   = TDIV - 1;
        m_par  = 1'b0;
        m_step = 1'b0;
        m_lfsr = 16'hACE1;
        for (int y = 0; y < 16; y++) begin
            pend[y]    = 3'b000;
            pend_n[y]  = 0;
            m_shift[y] = 1'b0;
            for (int x = 0; x < 16; x++) m_grid[y][x] = 1'b0;
        end
    endtask

    // Next pixel to enter lane y: drain the pending car/gap pixels, else ask the LFSR.
    task automatic next_entry(input int y, output bit e);
        if (pend_n[y] > 0) begin
            e = pend[y][0];
            pend[y] = pend[y] >> 1;
            pend_n[y]--;
        end else begin
            e = m_lfsr[y];
            if (e) begin
                pend[y]   = 3'b001;
                pend_n[y] = 3;
            end
        end
    endtask

    task automatic model_edge();
        bit tk;
        bit e;
        for (int y = 0; y < 16; y++) m_shift[y] = 1'b0;
        if (clear) begin
            model_reset_road();
        end else begin
            tk = !freeze && (m_cnt == m_tc);
            m_step = tk;
            if (tk) begin
                m_cnt = 0;
                m_tc  = calc_tc(int'(level));
                for (int y = 0; y < 16; y++) begin
                    if (MASK[y] && (((y / 2) % 2) == 0 || m_par)) begin
                        next_entry(y, e);
                        if (y % 2 == 1) begin
                            for (int x = 0; x < 15; x++) m_grid[y][x] = m_grid[y][x+1];
                            m_grid[y][15] = e;
                        end else begin
                            for (int x = 15; x > 0; x--) m_grid[y][x] = m_grid[y][x-1];
                            m_grid[y][0] = e;
                        end
                        m_shift[y] = 1'b1;
                    end
                end
                m_par  = !m_par;
                m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            end else if (!freeze) begin
                m_cnt++;
            end
        end
    endtask

    task automatic model_reset_road();
        logic [15:0] keep;
        keep = m_lfsr;
        model_reset();
        m_lfsr = keep;
        m_tc   = calc_tc(int'(level));
    endtask

    task automatic cycle();
        logic [255:0] mrows;
        bit obs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("grid", RedPixels, exp_grid());
        chk("step", step, m_step);
        if (track) begin
            mrows = '0;
            for (int x = 0; x < 16; x++) begin
                mrows[x]      = RedPixels[x][0];
                mrows[16 + x] = RedPixels[x][7];
                mrows[32 + x] = RedPixels[x][8];
                mrows[48 + x] = RedPixels[x][15];
            end
            chk("masked_rows", mrows, 0);
            if (step) n_steps++;
            for (int y = 0; y < 16; y++) begin
                if (m_shift[y]) begin
                    sh_cnt[y]++;
                    obs = RedPixels[(y % 2 == 1) ? 15 : 0][y];
                    if (obs == run_val[y]) begin
                        run_len[y]++;
                    end else begin
                        if (run_val[y]) chk("car_len", run_len[y], 2);
                        else if (seen_one[y]) chk("gap_min", run_len[y] >= 2, 1);
                        if (obs) seen_one[y] = 1'b1;
                        run_val[y] = obs;
                        run_len[y] = 1;
                    end
                end
            end
        end
    endtask

    task automatic wait_step(output int d);
        d = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            d++;
            if (step) break;
        end
    endtask

    initial begin
        logic [255:0] snap;
        logic [15:0]  lfsr_before;
        bit           got;
        int           d;
        int           cyc;

        n_checks = 0;
        n_pass   = 0;
        track    = 1'b0;
        n_steps  = 0;
        model_reset();

        // Power-on reset held for three edges.
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_grid", RedPixels, 0);
            chk("rst_step", step, 0);
        end
        reset = 1'b1;

        repeat (3) cycle();
        cycle();
        chk("first_step", step, 1);
        chk("t1_l5_x15", RedPixels[15][5], 1);
        chk("t1_l6_x0", RedPixels[0][6], 0);
        repeat (4) cycle();
        chk("t2_step", step, 1);
        chk("t2_l5_x14", RedPixels[14][5], 1);
        chk("t2_l5_x15", RedPixels[15][5], 1);
        repeat (4) cycle();
        chk("t3_l5_x15", RedPixels[15][5], 0);
        repeat (4) cycle();
        chk("t4_l5_x15", RedPixels[15][5], 0);

        // Freeze mid-period for 40 cycles.
        repeat (6) cycle();
        freeze = 1'b1;
        snap = RedPixels;
        repeat (40) begin
            cycle();
            chk("frz_grid", RedPixels, snap);
            chk("frz_step", step, 0);
        end
        freeze = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            cycle();
            if (step) got = 1'b1;
        end
        chk("frz_resume", got, 1);

        // Clear landing on a tick edge.
        repeat (5) cycle();
        for (int i = 0; i < 8 && m_cnt != m_tc; i++) cycle();
        lfsr_before = m_lfsr;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clr_grid", RedPixels, 0);
        chk("clr_step", step, 0);
        chk("clr_lfsr", dut.lfsr, lfsr_before);
        repeat (9) cycle();

        // Asynchronous reset mid-run.
        #2 reset = 1'b0;
        #1;
        chk("arst_grid", RedPixels, 0);
        chk("arst_step", step, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cycle();
        chk("arst_no_early_step", step, 0);
        cycle();
        chk("arst_first_step", step, 1);

        // Randomized run with sporadic freezes, starting from a cleared road.
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int y = 0; y < 16; y++) begin
            sh_cnt[y]   = 0;
            run_len[y]  = 0;
            run_val[y]  = 1'b0;
            seen_one[y] = 1'b0;
        end
        n_steps = 0;
        track   = 1'b1;
        cyc     = 0;
        while (n_steps < 2000 && cyc < 20000) begin
            freeze = ($urandom_range(0, 7) == 0);
            cycle();
            cyc++;
        end
        freeze = 1'b0;
        track  = 1'b0;
        chk("rand_steps", n_steps, 2000);
        for (int y = 0; y < 16; y++) begin
            if (MASK[y]) begin
                if (((y / 2) % 2) == 1) chk("slow_rate", sh_cnt[y], n_steps / 2);
                else chk("fast_rate", sh_cnt[y], n_steps);
            end
        end

`ifdef TRAFFIC_SPEEDUP_EN
        // Speed levels: a new level applies from the next period.
        level = 2'd1;
        wait_step(d);
        wait_step(d);
        chk("lvl1_period_a", d, 2);
        wait_step(d);
        chk("lvl1_period_b", d, 2);
        cycle();
        level = 2'd0;
        wait_step(d);
        chk("lvl0_finish_old", d, 1);
        wait_step(d);
        chk("lvl0_period", d, 4);
        wait_step(d);
        chk("lvl0_period_b", d, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
